// File: rtl/ppu_regport.sv
// ppu_regport -- CPU-side responder for the PPU VRAM address/data ports.
//
// Decodes CPU sysbus cycles in $2000-$3FFF (index = addr[2:0], mirrored
// every 8 bytes). It holds the VRAM address register v, the two-write toggle w,
// the increment select inc32 and the read buffer rbuf. VRAM accesses go
// through a req/ack handshake with the PPU memory arbiter.
//
// Optional feature macro: PPU_PALETTE_BYPASS_EN
//   When it is defined, a $2007 read with v in $3F00-$3FFF returns the fetched
//   byte directly, one cycle after vack. rdy is held low until that byte is
//   returned. When it is undefined, palette reads are buffered like every
//   other address.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   addr, rd, wr     CPU sysbus address and one-cycle strobes (wr wins)
//   data_in          CPU write data
//   data_out/data_oe registered read data plus its one-cycle valid/drive enable
//   rdy              combinational; 0 = access not taken, CPU must re-present
//   vaddr            VRAM address (current v)
//   vdata_out        VRAM write data
//   vdata_in         VRAM read data, valid with vack
//   vrd, vwr         VRAM requests, held until vack
//   vack             single-cycle arbiter acknowledge
module ppu_regport #(
  parameter int VADDR_N = 14,
  parameter int DATA_N  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        addr,
  input  logic               rd,
  input  logic               wr,
  input  logic [DATA_N-1:0]  data_in,
  output logic [DATA_N-1:0]  data_out,
  output logic               data_oe,
  output logic               rdy,
  output logic [VADDR_N-1:0] vaddr,
  output logic [DATA_N-1:0]  vdata_out,
  input  logic [DATA_N-1:0]  vdata_in,
  output logic               vrd,
  output logic               vwr,
  input  logic               vack
);

`ifdef PPU_PALETTE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ} state_t;

  state_t             state;
  logic [VADDR_N-1:0] v;
  logic               w;
  logic               inc32;
  logic [DATA_N-1:0]  rbuf;
  logic               byp;    // a palette read is waiting to return direct data

  logic       cs;
  logic [2:0] idx;
  logic       access;
  logic       take;
  logic       palette;
  logic       unused_addr_bits;

  // The address wraps modulo 2^VADDR_N by truncation.
  function automatic logic [VADDR_N-1:0] next_v(input logic [VADDR_N-1:0] cur,
                                                input logic big);
    return cur + (big ? VADDR_N'(32) : VADDR_N'(1));
  endfunction

  assign cs               = (addr[15:13] == 3'b001);
  assign idx              = addr[2:0];
  assign access           = cs && (rd || wr);
  assign take             = access && (state == IDLE);
  assign palette          = &v[VADDR_N-1:8];
  assign unused_addr_bits = ^addr[12:3];

  // Any decoded access during a pending VRAM request is refused. A pending
  // bypass read also holds rdy low until its data has been returned.
  assign rdy   = !(access && (state != IDLE)) && !byp;
  assign vaddr = v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      v         <= '0;
      w         <= 1'b0;
      inc32     <= 1'b0;
      rbuf      <= '0;
      byp       <= 1'b0;
      vrd       <= 1'b0;
      vwr       <= 1'b0;
      vdata_out <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
    end else begin
      data_oe <= 1'b0;
      case (state)
        IDLE: begin
          if (take && wr) begin
            case (idx)
              3'd0: inc32 <= data_in[2];
              3'd6: begin
                if (!w) v[VADDR_N-1:8] <= data_in[VADDR_N-9:0];
                else    v[7:0]         <= data_in[7:0];
                w <= !w;
              end
              3'd7: begin
                vdata_out <= data_in;
                vwr       <= 1'b1;
                state     <= WR_REQ;
              end
              default: ;
            endcase
          end else if (take && rd) begin
            // Every register except $2007 reads back as zero.
            data_out <= '0;
            data_oe  <= 1'b1;
            if (idx == 3'd2) w <= 1'b0;
            if (idx == 3'd7) begin
              vrd   <= 1'b1;
              state <= RD_REQ;
              if (BYPASS && palette) begin
                byp     <= 1'b1;
                data_oe <= 1'b0;
              end else begin
                data_out <= rbuf;
              end
            end
          end
        end
        WR_REQ: begin
          if (vack) begin
            vwr   <= 1'b0;
            v     <= next_v(v, inc32);
            state <= IDLE;
          end
        end
        RD_REQ: begin
          if (vack) begin
            rbuf  <= vdata_in;
            vrd   <= 1'b0;
            v     <= next_v(v, inc32);
            state <= IDLE;
            if (byp) begin
              data_out <= vdata_in;
              data_oe  <= 1'b1;
              byp      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_regport.sv
// Directed bench for ppu_regport. Inputs change on the falling edge and
// outputs are checked on the following falling edge.
module tb_ppu_regport;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rd = 1'b0, wr = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        rdy;
  logic [13:0] vaddr;
  logic [7:0]  vdata_out;
  logic [7:0]  vdata_in = 8'h00;
  logic        vrd, vwr;
  logic        vack = 1'b0;

  int ncmp = 0;
  int nfail = 0;

  ppu_regport #(.VADDR_N(14), .DATA_N(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .rdy(rdy),
    .vaddr(vaddr), .vdata_out(vdata_out), .vdata_in(vdata_in),
    .vrd(vrd), .vwr(vwr), .vack(vack)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    addr = a; rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d);
    vdata_in = d; vack = 1'b1;
    @(negedge clk); vack = 1'b0;
  endtask

  task automatic set_v(input logic [13:0] a);
    cpu_wr(16'h2006, {2'b00, a[13:8]});
    cpu_wr(16'h2006, a[7:0]);
  endtask

  task automatic test_reset();
    do_reset();
    ncmp++; if (vaddr !== 14'h0) begin nfail++; $display("FAIL reset_vaddr got %h want 0000", vaddr); end
    ncmp++; if ({vrd, vwr, data_oe} !== 3'b000) begin nfail++; $display("FAIL reset_ctrl got %b want 000", {vrd, vwr, data_oe}); end
    ncmp++; if ({data_out, vdata_out} !== 16'h0) begin nfail++; $display("FAIL reset_data got %h want 0000", {data_out, vdata_out}); end
    ncmp++; if (rdy !== 1'b1) begin nfail++; $display("FAIL reset_rdy got %b want 1", rdy); end
  endtask

  task automatic test_addr_write();
    do_reset();
    cpu_wr(16'h2006, 8'h21); cpu_wr(16'h2006, 8'h08);
    ncmp++; if (vaddr !== 14'h2108) begin nfail++; $display("FAIL addr_2108 got %h want 2108", vaddr); end
    // w is back to 0, so the next write is the high byte; the $3FFE mirror decodes as $2006
    cpu_wr(16'h3FFE, 8'h3F);
    ncmp++; if (vaddr !== 14'h3F08) begin nfail++; $display("FAIL addr_mirror_hi got %h want 3F08", vaddr); end
    cpu_wr(16'h2006, 8'h00);
    // writes outside the decode leave v alone
    cpu_wr(16'h4006, 8'h12); cpu_wr(16'h4006, 8'h34);
    ncmp++; if (vaddr !== 14'h3F00) begin nfail++; $display("FAIL addr_nodecode got %h want 3F00", vaddr); end
    cpu_wr(16'h2006, 8'hFF); cpu_wr(16'h2006, 8'hFF);
    ncmp++; if (vaddr !== 14'h3FFF) begin nfail++; $display("FAIL addr_mask got %h want 3FFF", vaddr); end
  endtask

  task automatic test_data_write();
    int hi = 0;
    cpu_wr(16'h2007, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      if (vwr === 1'b1 && vdata_out === 8'hAA && vaddr === 14'h3FFF) hi++;
      if (i == 2) begin vack = 1'b1; @(negedge clk); vack = 1'b0; end
      else @(negedge clk);
    end
    ncmp++; if (hi !== 3) begin nfail++; $display("FAIL wr_hold got %0d want 3", hi); end
    ncmp++; if (vwr !== 1'b0) begin nfail++; $display("FAIL wr_drop got %b want 0", vwr); end
    ncmp++; if (vaddr !== 14'h0000) begin nfail++; $display("FAIL wr_wrap got %h want 0000", vaddr); end
  endtask

  task automatic test_read_inc32();
    do_reset();
    cpu_wr(16'h2000, 8'h04);
    set_v(14'h2000);
    cpu_rd(16'h2007);
    ncmp++; if ({data_oe, data_out, vrd} !== {1'b1, 8'h00, 1'b1}) begin nfail++; $display("FAIL rd1 got oe=%b d=%h vrd=%b want 1 00 1", data_oe, data_out, vrd); end
    ack(8'h11);
    ncmp++; if ({data_oe, vrd, vaddr} !== {2'b00, 14'h2020}) begin nfail++; $display("FAIL rd1_ack got oe=%b vrd=%b v=%h want 0 0 2020", data_oe, vrd, vaddr); end
    cpu_rd(16'h2007);
    ncmp++; if ({data_oe, data_out} !== {1'b1, 8'h11}) begin nfail++; $display("FAIL rd2 got oe=%b d=%h want 1 11", data_oe, data_out); end
    ack(8'h22);
    ncmp++; if (vaddr !== 14'h2040) begin nfail++; $display("FAIL rd2_v got %h want 2040", vaddr); end
    // +32 wraps modulo 2^14
    set_v(14'h3FF0);
    cpu_rd(16'h2007); ack(8'h33);
    ncmp++; if (vaddr !== 14'h0010) begin nfail++; $display("FAIL inc32_wrap got %h want 0010", vaddr); end
  endtask

  task automatic test_status_clear();
    do_reset();
    cpu_wr(16'h2006, 8'h05);
    cpu_rd(16'h2002);
    ncmp++; if ({data_oe, data_out} !== {1'b1, 8'h00}) begin nfail++; $display("FAIL status_rd got oe=%b d=%h want 1 00", data_oe, data_out); end
    @(negedge clk);
    ncmp++; if (data_oe !== 1'b0) begin nfail++; $display("FAIL oe_pulse got %b want 0", data_oe); end
    cpu_wr(16'h2006, 8'h23); cpu_wr(16'h2006, 8'hC0);
    ncmp++; if (vaddr !== 14'h23C0) begin nfail++; $display("FAIL status_w got %h want 23C0", vaddr); end
  endtask

  task automatic test_misc_reads();
    cpu_rd(16'h2003);
    ncmp++; if ({data_oe, data_out} !== {1'b1, 8'h00}) begin nfail++; $display("FAIL wo_rd got oe=%b d=%h want 1 00", data_oe, data_out); end
    cpu_rd(16'h4007);
    ncmp++; if ({data_oe, vrd} !== 2'b00) begin nfail++; $display("FAIL nodecode_rd got oe=%b vrd=%b want 0 0", data_oe, vrd); end
    // rd and wr together: the write to $2006 wins and nothing is driven back
    addr = 16'h2006; data_in = 8'h01; rd = 1'b1; wr = 1'b1;
    @(negedge clk); rd = 1'b0; wr = 1'b0;
    cpu_wr(16'h2006, 8'h02);
    ncmp++; if ({data_oe, vaddr} !== {1'b0, 14'h0102}) begin nfail++; $display("FAIL rdwr got oe=%b v=%h want 0 0102", data_oe, vaddr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_v(14'h1234);
    cpu_wr(16'h2007, 8'h55);
    addr = 16'h2006; data_in = 8'h3F; wr = 1'b1;
    #1;
    ncmp++; if (rdy !== 1'b0) begin nfail++; $display("FAIL busy_rdy got %b want 0", rdy); end
    @(negedge clk);
    ncmp++; if ({vwr, vaddr} !== {1'b1, 14'h1234}) begin nfail++; $display("FAIL busy_v got vwr=%b v=%h want 1 1234", vwr, vaddr); end
    vack = 1'b1; @(negedge clk); vack = 1'b0;
    ncmp++; if ({rdy, vaddr} !== {1'b1, 14'h1235}) begin nfail++; $display("FAIL busy_ack got rdy=%b v=%h want 1 1235", rdy, vaddr); end
    @(negedge clk); wr = 1'b0;
    ncmp++; if (vaddr !== 14'h3F35) begin nfail++; $display("FAIL represent got %h want 3F35", vaddr); end
    // zero-latency ack: second $2007 write two cycles after the first
    cpu_wr(16'h2006, 8'h35);
    cpu_wr(16'h2007, 8'h01); ack(8'h00);
    cpu_wr(16'h2007, 8'h02);
    ncmp++; if ({vwr, vdata_out, vaddr} !== {1'b1, 8'h02, 14'h3F36}) begin nfail++; $display("FAIL b2b got vwr=%b d=%h v=%h want 1 02 3F36", vwr, vdata_out, vaddr); end
    ack(8'h00);
  endtask

  task automatic test_reset_mid();
    set_v(14'h0100);
    cpu_wr(16'h2007, 8'h99);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    ncmp++; if ({vwr, vaddr} !== {1'b0, 14'h0000}) begin nfail++; $display("FAIL rst_mid got vwr=%b v=%h want 0 0000", vwr, vaddr); end
    ack(8'h00);
    ncmp++; if ({vrd, vwr, vaddr} !== {2'b00, 14'h0000}) begin nfail++; $display("FAIL late_ack got %b%b v=%h want 00 0000", vrd, vwr, vaddr); end
  endtask

  task automatic test_palette();
    do_reset();
    cpu_rd(16'h2007); ack(8'h77);
    set_v(14'h3F01);
    cpu_rd(16'h2007);
`ifdef PPU_PALETTE_BYPASS_EN
    ncmp++; if ({data_oe, rdy} !== 2'b00) begin nfail++; $display("FAIL byp_wait got oe=%b rdy=%b want 0 0", data_oe, rdy); end
    ack(8'h0F);
    ncmp++; if ({data_oe, data_out, rdy} !== {1'b1, 8'h0F, 1'b1}) begin nfail++; $display("FAIL byp_data got oe=%b d=%h rdy=%b want 1 0F 1", data_oe, data_out, rdy); end
`else
    ncmp++; if ({data_oe, data_out} !== {1'b1, 8'h77}) begin nfail++; $display("FAIL pal_buf got oe=%b d=%h want 1 77", data_oe, data_out); end
    ack(8'h0F);
`endif
    set_v(14'h2000);
    cpu_rd(16'h2007);
    ncmp++; if (data_out !== 8'h0F) begin nfail++; $display("FAIL pal_rbuf got %h want 0F", data_out); end
    ack(8'h00);
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_data_write();
    test_read_inc32();
    test_status_clear();
    test_misc_reads();
    test_back_to_back();
    test_reset_mid();
    test_palette();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
